// File: rtl/cgra_array_done_unit.sv
// cgra_array_done_unit
// Array-side completion detector. Counts executed context steps and finished
// program iterations while the control unit runs the array, and raises a
// sticky done on the configured iteration count or (optionally) when every
// selected PE has halted.
// Optional feature macro: CGRA_DONE_HALT_EN enables all-halt completion.
module cgra_array_done_unit #(
  parameter int PC_WIDTH   = 4,
  parameter int NUM_PE     = 16,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_enable_i,
  input  logic                  pe_reset_n_i,
  input  logic                  global_stall_i,
  input  logic [PC_WIDTH-1:0]   context_pc_i,
  input  logic [PC_WIDTH-1:0]   cfg_last_ctx_i,
  input  logic [ITER_WIDTH-1:0] cfg_iterations_i,
  input  logic [NUM_PE-1:0]     cfg_pe_mask_i,
  input  logic [NUM_PE-1:0]     pe_halt_i,
  output logic                  array_done_o,
  output logic [1:0]            done_cause_o,
  output logic [ITER_WIDTH-1:0] iter_count_o,
  output logic [31:0]           step_count_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   last_q, last_d;
  logic [ITER_WIDTH-1:0] limit_q, limit_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [31:0]           step_q, step_d;
  logic [1:0]            cause_q, cause_d;
  logic                  done_q, done_d;

  logic                  step;
  logic                  entering;
  logic [PC_WIDTH-1:0]   last_sel;
  logic [ITER_WIDTH-1:0] limit_sel;
  logic [ITER_WIDTH-1:0] iter_base;
  logic [31:0]           step_base;
  logic                  iter_ev;
  logic                  iter_inc;
  logic [ITER_WIDTH-1:0] iter_next;
  logic [31:0]           step_next;
  logic                  iter_hit;
  logic                  halt_hit;

`ifdef CGRA_DONE_HALT_EN
  logic [NUM_PE-1:0]     mask_q, mask_d;
  logic [NUM_PE-1:0]     mask_sel;
`else
  // Halt inputs stay on the port list but feed nothing in this build.
  logic                  unused_halt;
  assign unused_halt = ^{pe_halt_i, cfg_pe_mask_i};
`endif

  // Step/iteration qualification and completion conditions. On the entry
  // cycle the live config is used, since it is being latched this very cycle.
  always_comb begin
    step      = pe_enable_i && pe_reset_n_i && !global_stall_i;
    entering  = (state_q == S_IDLE) && pe_enable_i && pe_reset_n_i;
    last_sel  = entering ? cfg_last_ctx_i : last_q;
    limit_sel = entering ? cfg_iterations_i : limit_q;
    iter_base = entering ? '0 : iter_q;
    step_base = entering ? '0 : step_q;
    iter_ev   = step && (context_pc_i == last_sel);
    // Iteration counter saturates: no increment once all-ones.
    iter_inc  = iter_ev && (iter_base != {ITER_WIDTH{1'b1}});
    iter_next = iter_base + {{(ITER_WIDTH-1){1'b0}}, iter_inc};
    step_next = step_base + {31'd0, step};
    iter_hit  = iter_inc && (limit_sel != '0) && (iter_next == limit_sel);
`ifdef CGRA_DONE_HALT_EN
    mask_sel  = entering ? cfg_pe_mask_i : mask_q;
    halt_hit  = (mask_sel != '0) && ((pe_halt_i & mask_sel) == mask_sel);
`else
    halt_hit  = 1'b0;
`endif
  end

  // Next-state and register-update logic; soft reset overrides everything.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    limit_d = limit_q;
    iter_d  = iter_q;
    step_d  = step_q;
    cause_d = cause_q;
`ifdef CGRA_DONE_HALT_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (entering) begin
          last_d  = cfg_last_ctx_i;
          limit_d = cfg_iterations_i;
`ifdef CGRA_DONE_HALT_EN
          mask_d  = cfg_pe_mask_i;
`endif
          step_d  = step_next;
          iter_d  = iter_next;
          cause_d = 2'b00;
          if (iter_hit || halt_hit) begin
            state_d = S_DONE;
            cause_d = {halt_hit, iter_hit};
          end else begin
            state_d = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        step_d = step_next;
        iter_d = iter_next;
        if (iter_hit || halt_hit) begin
          state_d = S_DONE;
          cause_d = {halt_hit, iter_hit};
        end
      end
      S_DONE: begin
        // Counters frozen; drain-cycle steps are ignored.
        if (!pe_enable_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!pe_reset_n_i) begin
      state_d = S_IDLE;
      iter_d  = '0;
      step_d  = '0;
      cause_d = 2'b00;
    end
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      limit_q <= '0;
      iter_q  <= '0;
      step_q  <= '0;
      cause_q <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      limit_q <= limit_d;
      iter_q  <= iter_d;
      step_q  <= step_d;
      cause_q <= cause_d;
      done_q  <= done_d;
    end
  end

`ifdef CGRA_DONE_HALT_EN
  // Latched halt mask.
  always_ff @(posedge clk) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end
`endif

  assign array_done_o = done_q;
  assign done_cause_o = cause_q;
  assign iter_count_o = iter_q;
  assign step_count_o = step_q;

endmodule
